// File: rtl/pkg_dtypes.sv
// Shared operand-fetch types: FSM state encoding and request / read-channel bundles
// used by the interconnect fetcher and, later, by the EU cache side.
package pkg_dtypes;

    localparam int unsigned ICON_ADDR_W = 8;
    localparam int unsigned ICON_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_WR0   = 3'd3,
        ST_RD1   = 3'd4,
        ST_WAIT1 = 3'd5,
        ST_WR1   = 3'd6
    } type_icon_fetch_state;

    typedef struct packed {
        logic [ICON_ADDR_W-1:0] op0_addr;
        logic                   op0_en;
        logic [ICON_ADDR_W-1:0] op1_addr;
        logic                   op1_en;
    } type_icon_fetch_req;

    typedef struct packed {
        logic [ICON_ADDR_W-1:0] addr;
        logic                   valid;
        logic [ICON_DATA_W-1:0] data;
        logic                   success;
    } type_icon_rd_channel;

endpackage

// File: rtl/icon_retry_timer.sv
// Retry and backoff counters for the operand fetcher; one instance serves both operands
// because only one operand is ever being read at a time.
module icon_retry_timer #(
    parameter int unsigned MAX_RETRY = 15,
    parameter int unsigned BACKOFF   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic fail_i,
    input  logic wait_i,
    output logic exhausted_o,
    output logic expire_o
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned BW = (BACKOFF < 1) ? 1 : $clog2(BACKOFF + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [BW-1:0] BO_LAST   = BW'((BACKOFF > 0) ? BACKOFF - 1 : 0);

    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic [BW-1:0] bo_cnt_q, bo_cnt_d;

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (clr_i) begin
            retry_cnt_d = '0;
        end else if (fail_i && (retry_cnt_q != RETRY_MAX)) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
        end
    end

    // Backoff count restarts from zero every time a wait period begins.
    always_comb begin
        bo_cnt_d = '0;
        if (wait_i) begin
            bo_cnt_d = (bo_cnt_q == BO_LAST) ? bo_cnt_q : bo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt_q <= '0;
            bo_cnt_q    <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            bo_cnt_q    <= bo_cnt_d;
        end
    end

    assign exhausted_o = (retry_cnt_q == RETRY_MAX);
    assign expire_o    = wait_i && (bo_cnt_q == BO_LAST);

endmodule

// File: rtl/eu_icon_operand_fetcher.sv
// Interconnect-side operand fetcher: reads op0/op1 from a producer EU cache with retry
// and backoff, then writes each operand into the consumer cache write channels.
module eu_icon_operand_fetcher
    import pkg_dtypes::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_RETRY = 15,
    parameter int unsigned BACKOFF   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_op0_addr_i,
    input  logic              req_op0_en_i,
    input  logic [ADDR_W-1:0] req_op1_addr_i,
    input  logic              req_op1_en_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_valid_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_success_i,
    output logic              w0_valid_o,
    output logic [ADDR_W-1:0] w0_addr_o,
    output logic [DATA_W-1:0] w0_data_o,
    input  logic              w0_ready_i,
    output logic              w1_valid_o,
    output logic [ADDR_W-1:0] w1_addr_o,
    output logic [DATA_W-1:0] w1_data_o,
    input  logic              w1_ready_i,
    output logic              busy_o,
    output logic              timeout_o
);

    type_icon_fetch_state state_q, state_d;
    logic [ADDR_W-1:0]    op0_addr_q, op0_addr_d;
    logic [ADDR_W-1:0]    op1_addr_q, op1_addr_d;
    logic                 op1_en_q, op1_en_d;
    logic [DATA_W-1:0]    data0_q, data0_d;
    logic [DATA_W-1:0]    data1_q, data1_d;
    logic                 timeout_q, timeout_d;
    logic                 in_read, in_wait, exhausted, expire;

    assign in_read = (state_q == ST_RD0) || (state_q == ST_RD1);
    assign in_wait = (state_q == ST_WAIT0) || (state_q == ST_WAIT1);

    icon_retry_timer #(
        .MAX_RETRY(MAX_RETRY),
        .BACKOFF  (BACKOFF)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (!(in_read || in_wait)),
        .fail_i     (in_read && !rd_success_i),
        .wait_i     (in_wait),
        .exhausted_o(exhausted),
        .expire_o   (expire)
    );

    always_comb begin
        state_d    = state_q;
        op0_addr_d = op0_addr_q;
        op1_addr_d = op1_addr_q;
        op1_en_d   = op1_en_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op0_addr_d = req_op0_addr_i;
                    op1_addr_d = req_op1_addr_i;
                    op1_en_d   = req_op1_en_i;
                    if (req_op0_en_i)      state_d = ST_RD0;
                    else if (req_op1_en_i) state_d = ST_RD1;
                end
            end
            ST_RD0: begin
                if (rd_success_i) begin
                    data0_d = rd_data_i;
                    state_d = ST_WR0;
                end else if (exhausted) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = (BACKOFF == 0) ? ST_RD0 : ST_WAIT0;
                end
            end
            ST_WAIT0: if (expire) state_d = ST_RD0;
            ST_WR0: begin
                if (w0_ready_i) state_d = op1_en_q ? ST_RD1 : ST_IDLE;
            end
            ST_RD1: begin
                if (rd_success_i) begin
                    data1_d = rd_data_i;
                    state_d = ST_WR1;
                end else if (exhausted) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = (BACKOFF == 0) ? ST_RD1 : ST_WAIT1;
                end
            end
            ST_WAIT1: if (expire) state_d = ST_RD1;
            ST_WR1:   if (w1_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op0_addr_q <= '0;
            op1_addr_q <= '0;
            op1_en_q   <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op0_addr_q <= op0_addr_d;
            op1_addr_q <= op1_addr_d;
            op1_en_q   <= op1_en_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            timeout_q  <= timeout_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign timeout_o   = timeout_q;
    assign rd_valid_o  = in_read;
    assign rd_addr_o   = (state_q == ST_RD0) ? op0_addr_q :
                         (state_q == ST_RD1) ? op1_addr_q : '0;
    assign w0_valid_o  = (state_q == ST_WR0);
    assign w0_addr_o   = op0_addr_q;
    assign w0_data_o   = data0_q;
    assign w1_valid_o  = (state_q == ST_WR1);
    assign w1_addr_o   = op1_addr_q;
    assign w1_data_o   = data1_q;

endmodule

// File: tb/tb_eu_icon_operand_fetcher.sv
// Scoreboard bench for eu_icon_operand_fetcher: planned cache behaviour per request,
// expected writes/timeouts queued at issue and popped by an independent monitor.
module tb_eu_icon_operand_fetcher;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MR = 15;
    localparam int unsigned BO = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_op0_addr, req_op1_addr;
    logic          req_op0_en, req_op1_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_success;
    logic          w0_valid, w0_ready, w1_valid, w1_ready;
    logic [AW-1:0] w0_addr, w1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic          busy, timeout;

    eu_icon_operand_fetcher #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MR), .BACKOFF(BO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op0_addr_i(req_op0_addr), .req_op0_en_i(req_op0_en),
        .req_op1_addr_i(req_op1_addr), .req_op1_en_i(req_op1_en),
        .rd_addr_o(rd_addr), .rd_valid_o(rd_valid),
        .rd_data_i(rd_data), .rd_success_i(rd_success),
        .w0_valid_o(w0_valid), .w0_addr_o(w0_addr), .w0_data_o(w0_data), .w0_ready_i(w0_ready),
        .w1_valid_o(w1_valid), .w1_addr_o(w1_addr), .w1_data_o(w1_data), .w1_ready_i(w1_ready),
        .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            fails;
        logic [DW-1:0] data;
    } rd_plan_t;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    rd_plan_t rdq[$];
    exp_t     expq[$];
    int       checks = 0;
    int       failures = 0;
    int       rdy_mode = 0;
    int       w1_seen = 0;
    int       busy_n, w1v_n;
    bit       pat[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Cache responder and write-ready driver.
    always @(negedge clk) begin
        case (rdy_mode)
            0: begin w0_ready = 1'b1; w1_ready = 1'b1; end
            1: begin w0_ready = ($urandom_range(0, 2) != 0); w1_ready = ($urandom_range(0, 2) != 0); end
            2: begin
                w0_ready = 1'b1;
                if (w1_valid) begin
                    w1_ready = (w1_seen >= 5);
                    w1_seen++;
                end else begin
                    w1_ready = 1'b0;
                    w1_seen  = 0;
                end
            end
            default: begin w0_ready = 1'b0; w1_ready = 1'b0; end
        endcase
        rd_success = 1'b0;
        rd_data    = $urandom;
        if (!reset && rd_valid) begin
            if (rdq.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                chk("rd_addr", rd_addr, rdq[0].addr);
                if (rdq[0].fails > 0) begin
                    rdq[0].fails = rdq[0].fails - 1;
                end else begin
                    rd_success = 1'b1;
                    rd_data    = rdq[0].data;
                    void'(rdq.pop_front());
                end
            end
        end
    end

    // Monitor: scoreboard pops plus protocol rules.
    bit            p0_pend, p1_pend, gap_armed;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_data, p1_data;
    int            gap, fail_run;
    exp_t          e;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                p0_pend = 0; p1_pend = 0; gap_armed = 0; fail_run = 0;
            end else begin
                chk("valid_onehot", (32'(rd_valid) + 32'(w0_valid) + 32'(w1_valid)) <= 1, 1);
                chk("busy_vs_ready", busy, !req_ready);
                if (p0_pend) chk("w0_hold", {w0_valid, w0_addr, w0_data}, {1'b1, p0_addr, p0_data});
                if (p1_pend) chk("w1_hold", {w1_valid, w1_addr, w1_data}, {1'b1, p1_addr, p1_data});
                p0_pend = w0_valid && !w0_ready; p0_addr = w0_addr; p0_data = w0_data;
                p1_pend = w1_valid && !w1_ready; p1_addr = w1_addr; p1_data = w1_data;
                if (w0_valid && w0_ready) begin
                    if (expq.size() == 0) chk("w0_unexpected", 1, 0);
                    else begin e = expq.pop_front(); chk("w0_write", {2'd0, w0_addr, w0_data}, e); end
                end
                if (w1_valid && w1_ready) begin
                    if (expq.size() == 0) chk("w1_unexpected", 1, 0);
                    else begin e = expq.pop_front(); chk("w1_write", {2'd1, w1_addr, w1_data}, e); end
                end
                if (timeout) begin
                    if (expq.size() == 0) chk("timeout_unexpected", 1, 0);
                    else begin e = expq.pop_front(); chk("timeout_event", {2'd2, 40'h0}, e); end
                end
                if (rd_valid) begin
                    if (gap_armed) chk("backoff_gap", gap, BO);
                    gap_armed = 0;
                    if (!rd_success) begin
                        fail_run++;
                        if (fail_run <= MR) begin gap_armed = 1; gap = 0; end
                        else fail_run = 0;
                    end else begin
                        fail_run = 0;
                    end
                end else if (gap_armed) begin
                    gap++;
                end
            end
        end
    end

    // Issue one request at a negedge while idle; the expected outcome is derived here.
    task automatic start_req(input logic [AW-1:0] a0, input bit e0, input logic [AW-1:0] a1, input bit e1,
                             input int f0, input int f1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int n = 0;
        bit dead = 0;
        while (!req_ready && n < 2000) begin @(negedge clk); n++; end
        chk("ready_before_req", req_ready, 1);
        rdq.delete();
        if (e0) begin
            rdq.push_back('{a0, f0, d0});
            if (f0 > int'(MR)) begin expq.push_back({2'd2, 40'h0}); dead = 1; end
            else expq.push_back({2'd0, a0, d0});
        end
        if (e1 && !dead) begin
            rdq.push_back('{a1, f1, d1});
            if (f1 > int'(MR)) expq.push_back({2'd2, 40'h0});
            else expq.push_back({2'd1, a1, d1});
        end
        req_op0_addr = a0; req_op0_en = e0; req_op1_addr = a1; req_op1_en = e1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        busy_n = 0; w1v_n = 0; pat.delete();
        while (!req_ready && n < 2000) begin
            busy_n++;
            if (w1_valid) w1v_n++;
            pat.push_back(rd_valid);
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", n < 2000, 1);
    endtask

    initial begin
        int a0, a1, e0, e1, f0, f1, n;
        reset = 1'b1; req_valid = 1'b0; req_op0_addr = '0; req_op1_addr = '0;
        req_op0_en = 1'b0; req_op1_en = 1'b0; rdy_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_outputs", {busy, rd_valid, w0_valid, w1_valid, timeout}, 5'b0);
        chk("rst_addr_data", {rd_addr, w0_addr, w0_data, w1_addr}, 56'h0);
        @(negedge clk); #3 reset = 1'b0;
        @(negedge clk);

        start_req(8'h12, 1, 8'h34, 1, 0, 0, 32'hDEADBEEF, 32'h0BADF00D);
        wait_idle();
        chk("t1_busy_cycles", busy_n, 4);

        start_req(8'hA0, 1, 8'h00, 0, 2, 0, 32'h11112222, 32'h0);
        wait_idle();
        chk("t2_pattern_len", pat.size(), 10);
        for (int i = 0; i < 9 && i < pat.size(); i++)
            chk("t2_rd_valid_pattern", pat[i], (i % 4) == 0);

        start_req(8'h77, 1, 8'h78, 1, MR + 1, 0, 32'hCAFE0001, 32'hCAFE0002);
        wait_idle();
        chk("t3_timeout_busy", busy_n, (MR + 1) + MR * BO);

        rdy_mode = 2;
        start_req(8'h21, 1, 8'h43, 1, 0, 0, 32'h01234567, 32'h89ABCDEF);
        wait_idle();
        chk("t4_w1_valid_cycles", w1v_n, 6);
        rdy_mode = 0;

        start_req(8'h55, 0, 8'h66, 1, 1, 0, 32'h0, 32'h66666666);
        wait_idle();
        start_req(8'h01, 0, 8'h02, 0, 0, 0, 32'h0, 32'h0);
        wait_idle();
        chk("t5_noen_busy", busy_n, 0);

        rdy_mode = 3;
        start_req(8'h3C, 1, 8'h3D, 1, 0, 0, 32'h3C3C3C3C, 32'h3D3D3D3D);
        n = 0;
        while (!w0_valid && n < 50) begin @(negedge clk); n++; end
        chk("t6_reached_wr0", w0_valid, 1);
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_outputs", {busy, rd_valid, w0_valid, w1_valid, timeout, req_ready}, 6'b000001);
        chk("t6_rst_addr_data", {rd_addr, w0_addr, w0_data}, 48'h0);
        expq.delete(); rdq.delete();
        @(negedge clk); #3 reset = 1'b0; rdy_mode = 0;
        @(negedge clk);
        start_req(8'h5A, 1, 8'h5B, 0, MR, 0, 32'h5A5A0000, 32'h0);
        wait_idle();

        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            a0 = $urandom_range(0, 255); a1 = $urandom_range(0, 255);
            e0 = $urandom_range(0, 1);   e1 = $urandom_range(0, 1);
            f0 = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 2);
            f1 = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 2);
            start_req(AW'(a0), e0[0], AW'(a1), e1[0], f0, f1, $urandom, $urandom);
            wait_idle();
        end

        rdy_mode = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
